// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A granted requester keeps ownership for up to MAX_BURST accepted words.
//   state | meaning
//   IDLE  | no owner; pick the first valid requester starting at rr_ptr
//   BURST | owner locked; only the owner may write until release
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 2,
    parameter int CNT_W     = 16,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      ARES_design_CLK,
    input  logic                      ARES_design_RESET_N,
    input  logic                      arb_enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         ARES_design_WData,
    output logic                      ARES_design_Write,
    input  logic                      ARES_design_Full,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id,
    output logic [CNT_W-1:0]          accepted_cnt
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_n;
    logic [ID_W-1:0] owner, owner_n;
    logic [ID_W-1:0] rr_ptr, rr_ptr_n;
    logic [3:0]      burst_cnt, burst_cnt_n;
    logic [CNT_W-1:0] cnt_q;

    logic [ID_W-1:0] sel;
    logic            sel_exists;
    logic            accept;
    logic [NUM_REQ-1:0] ready_n;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    always_ff @(posedge ARES_design_CLK or negedge ARES_design_RESET_N) begin
        if (!ARES_design_RESET_N) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_cnt_n;
            if (accept)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        int idx;
        sel        = owner;
        sel_exists = 1'b0;
        idx        = 0;
        if (state == BURST) begin
            sel_exists = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ)
                    idx = idx - NUM_REQ;
                if (!sel_exists && req_valid[idx]) begin
                    sel_exists = 1'b1;
                    sel        = ID_W'(idx);
                end
            end
        end
    end

    // Gating with reset keeps outputs quiet while reset is held, even mid-cycle.
    assign accept = ARES_design_RESET_N & arb_enable & ~ARES_design_Full
                    & sel_exists & req_valid[sel];

    always_comb begin
        ready_n      = '0;
        ready_n[sel] = accept;
    end

    assign req_ready         = ready_n;
    assign ARES_design_Write = accept;
    assign ARES_design_WData = accept ? req_data[int'(sel)*DATA_W +: DATA_W] : '0;
    assign grant_valid       = ARES_design_RESET_N & (state == BURST);
    assign grant_id          = owner;
    assign accepted_cnt      = cnt_q;

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (MAX_BURST == 1) begin
                        rr_ptr_n = next_id(sel);
                    end else begin
                        state_n     = BURST;
                        owner_n     = sel;
                        burst_cnt_n = 4'd1;
                    end
                end
            end
            BURST: begin
                if (!arb_enable || ARES_design_Full) begin
                    state_n = BURST;
                end else if (!req_valid[owner]) begin
                    state_n     = IDLE;
                    rr_ptr_n    = next_id(owner);
                    burst_cnt_n = '0;
                end else if (accept) begin
                    if ((burst_cnt + 4'd1) == 4'(MAX_BURST)) begin
                        state_n     = IDLE;
                        rr_ptr_n    = next_id(owner);
                        burst_cnt_n = '0;
                    end else begin
                        burst_cnt_n = burst_cnt + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed plus randomized bench for fifo_write_arbiter against a
// transaction-level model of ownership, priority pointer and word count.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 2;
    localparam int CW = 16;
    localparam int IW = 2;

    logic              clk;
    logic              rst_n;
    logic              arb_enable;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     wdata;
    logic              write;
    logic              full;
    logic              grant_valid;
    logic [IW-1:0]     grant_id;
    logic [CW-1:0]     accepted_cnt;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
        .ARES_design_CLK    (clk),
        .ARES_design_RESET_N(rst_n),
        .arb_enable         (arb_enable),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_ready          (req_ready),
        .ARES_design_WData  (wdata),
        .ARES_design_Write  (write),
        .ARES_design_Full   (full),
        .grant_valid        (grant_valid),
        .grant_id           (grant_id),
        .accepted_cnt       (accepted_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the port, how many words used, next priority.
    bit          m_locked;
    int          m_owner;
    int          m_used;
    int          m_ptr;
    logic [CW-1:0] m_cnt;
    logic [N-1:0]  m_last_ready;

    bit          use_fifo;
    bit          drain;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] obs_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_used   = 0;
        m_ptr    = 0;
        m_cnt    = '0;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        int cand;
        int i;
        bit ex;
        bit acc;
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_wd;
        if (use_fifo) full = (fifo_q.size() >= 4);
        #1;
        ex = 0;
        cand = 0;
        if (m_locked) begin
            cand = m_owner;
            ex = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (!ex && req_valid[i]) begin
                    ex = 1;
                    cand = i;
                end
            end
        end
        acc = arb_enable && !full && ex && req_valid[cand];
        exp_ready = acc ? (N'(1) << cand) : '0;
        exp_wd = acc ? req_data[cand*DW +: DW] : '0;
        chk("write", write, acc);
        chk("ready", req_ready, exp_ready);
        chk("wdata", wdata, exp_wd);
        chk("grant_valid", grant_valid, m_locked);
        if (m_locked) chk("grant_id", grant_id, m_owner);
        chk("accepted_cnt", accepted_cnt, m_cnt);
        if (write) obs_q.push_back(wdata);
        m_last_ready = exp_ready;
        @(posedge clk);
        if (!m_locked) begin
            if (acc) begin
                m_cnt++;
                if (MB == 1) m_ptr = (cand + 1) % N;
                else begin
                    m_locked = 1;
                    m_owner = cand;
                    m_used = 1;
                end
            end
        end else if (arb_enable && !full) begin
            if (!req_valid[m_owner]) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % N;
            end else begin
                m_cnt++;
                m_used++;
                if (m_used == MB) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end
        end
        if (use_fifo && acc) fifo_q.push_back(exp_wd);
        if (use_fifo && drain && fifo_q.size() > 0) void'(fifo_q.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        arb_enable = 1'b1;
        req_valid = '1;
        req_data = '1;
        full = 1'b0;
        #1;
        chk("rst_write", write, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_cnt", accepted_cnt, 0);
        model_reset();
        fifo_q.delete();
        obs_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        req_data = '0;
    endtask

    initial begin
        int exp2[10];
        logic [CW-1:0] cnt_hold;
        rst_n = 1'b1;
        arb_enable = 1'b0;
        req_valid = '0;
        req_data = '0;
        full = 1'b0;
        use_fifo = 0;
        drain = 0;
        m_last_ready = '0;
        @(negedge clk);
        do_reset();

        // Single requester feeding a 4-deep FIFO that is never drained
        use_fifo = 1;
        drain = 0;
        req_valid = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            req_data[0 +: DW] = DW'(15 + obs_q.size());
            cycle();
        end
        chk("t1_fifo_size", fifo_q.size(), 4);
        for (int k = 0; k < 4; k++) chk("t1_fifo_word", fifo_q[k], 15 + k);
        chk("t1_cnt", accepted_cnt, 4);
        chk("t1_full", full, 1);
        use_fifo = 0;

        // All requesters valid with a drained FIFO
        do_reset();
        full = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(i);
        for (int c = 0; c < 10; c++) cycle();
        exp2 = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        chk("t2_count", obs_q.size(), 10);
        for (int k = 0; k < 10; k++) chk("t2_order", obs_q[k], exp2[k]);

        // Owner drops valid after one word: bubble, then req2 gets the grant
        do_reset();
        req_valid = 4'b0101;
        req_data[0 +: DW] = 32'hA0;
        req_data[2*DW +: DW] = 32'hA2;
        cycle();
        req_valid = 4'b0100;
        cycle();
        chk("t3_released", grant_valid, 0);
        cycle();
        chk("t3_gv", grant_valid, 1);
        chk("t3_gid", grant_id, 2);

        // FIFO full for three cycles in the middle of req2's burst
        req_valid = 4'b1100;
        req_data[3*DW +: DW] = 32'hA3;
        full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t4_hold_gid", grant_id, 2);
            chk("t4_hold_gv", grant_valid, 1);
        end
        full = 1'b0;
        cycle();
        chk("t4_last_word", obs_q[obs_q.size()-1], 32'hA2);
        cycle();
        chk("t4_rot_gid", grant_id, 3);
        chk("t4_rot_word", obs_q[obs_q.size()-1], 32'hA3);
        cycle();

        // Move priority to req2, then hold arbitration off with everyone valid
        req_valid = 4'b0010;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(32'hB0 + i);
        cycle();
        cycle();
        req_valid = 4'b1111;
        arb_enable = 1'b0;
        cnt_hold = accepted_cnt;
        for (int c = 0; c < 4; c++) cycle();
        chk("t5_cnt_frozen", accepted_cnt, cnt_hold);
        arb_enable = 1'b1;
        cycle();
        chk("t5_first_grant", grant_id, 2);
        chk("t5_first_word", obs_q[obs_q.size()-1], 32'hB2);

        // Asynchronous reset in the middle of a burst
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_write", write, 0);
        chk("t6_ready", req_ready, 0);
        chk("t6_gv", grant_valid, 0);
        chk("t6_cnt", accepted_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_gid", grant_id, 0);
        chk("t6_cnt_after", accepted_cnt, 0);
        @(negedge clk);

        // Randomized traffic obeying the hold-until-ready rule
        do_reset();
        for (int c = 0; c < 400; c++) begin
            arb_enable = ($urandom_range(9) != 0);
            full = ($urandom_range(4) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(1));
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            cycle();
            req_valid = req_valid & ~m_last_ready;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
